// File: rtl/nn_argmax.sv
// nn_argmax: streaming argmax over one sample of NUM_CLASSES signed scores.
// Scores arrive in class order; the index of the first strictly-largest
// score is published on label with a one-cycle done pulse.
module nn_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      score_valid,
    input  logic signed [SCORE_W-1:0] score,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                label
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_CLASSES - 1);

    state_t                    r_state;
    state_t                    w_next;
    logic [7:0]                r_cnt;
    logic [7:0]                r_best;
    logic [7:0]                r_label;
    logic signed [SCORE_W-1:0] r_max;

    logic       w_consume;
    logic       w_last;
    logic       w_take;
    logic [7:0] w_best_next;

    // A score is consumed only in ACCUM and only if no restart is requested
    // in the same cycle; class 0 always seeds the running max.
    assign w_consume   = (r_state == S_ACCUM) && score_valid && !start;
    assign w_last      = (r_cnt == LAST_IDX);
    assign w_take      = (r_cnt == 8'd0) || (score > r_max);
    assign w_best_next = w_take ? r_cnt : r_best;
    assign label       = r_label;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_ACCUM;
            end
            S_ACCUM: begin
                busy = 1'b1;
                if (w_consume && w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = start ? S_ACCUM : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Running-max datapath: start (in any state) clears the partial sample,
    // a consumed score updates max/best, and the last class commits the label.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 8'd0;
            r_best  <= 8'd0;
            r_max   <= '0;
            r_label <= 8'd0;
        end else if (start) begin
            r_cnt  <= 8'd0;
            r_best <= 8'd0;
            r_max  <= '0;
        end else if (w_consume) begin
            if (w_take) begin
                r_max  <= score;
                r_best <= r_cnt;
            end
            if (w_last) begin
                r_label <= w_best_next;
                r_cnt   <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_nn_argmax.sv
// Testbench for nn_argmax: table vectors, random samples against an
// argmax reference, and hand-written restart / reset / back-to-back sequences.
module tb_nn_argmax;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               score_valid;
    logic signed [15:0] score;
    logic               busy;
    logic               done;
    logic [7:0]         label;

    int errors = 0;
    int checks = 0;

    int  done_cnt = 0;
    time t_last   = 0;
    time t_prev   = 0;

    logic signed [15:0] sc[10];

    typedef struct packed {
        logic [9:0][15:0] s;
        logic [7:0]       exp;
        logic [1:0]       maxgap;
    } vec_t;

    vec_t vecs[6];

    nn_argmax #(.NUM_CLASSES(10), .SCORE_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .score_valid(score_valid),
        .score(score), .busy(busy), .done(done), .label(label)
    );

    always #5 clk = ~clk;

    // Count done pulses and remember when the last two occurred.
    always @(negedge clk) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            t_prev   = t_last;
            t_last   = $time;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: index of the first occurrence of the maximum score.
    function automatic int model_argmax();
        int b = 0;
        for (int k = 1; k < 10; k++) if (sc[k] > sc[b]) b = k;
        return b;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    // Feed the first n scores of sc[] (state must already be ACCUM).
    task automatic feed(input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            int g = $urandom_range(0, maxgap);
            repeat (g) begin
                @(posedge clk); #1;
                chk("gap_no_done", done, 0);
            end
            score_valid = 1'b1;
            score       = sc[i];
            @(posedge clk); #1;
            score_valid = 1'b0;
            score       = 16'sh5a5a;
            if (i < 9) begin
                chk("mid_no_done", done, 0);
                chk("mid_busy", busy, 1);
            end
        end
    endtask

    // Feed a full sample and check the completion cycle.
    task automatic run_scores(input int maxgap, input int exp);
        feed(10, maxgap);
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 0);
        chk("label", label, exp);
    endtask

    task automatic after_done(input int exp);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("label_hold", label, exp);
    endtask

    initial begin
        int exp;
        int dc;

        rst = 1'b1; start = 1'b0; score_valid = 1'b0; score = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_label", label, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        vecs[0].s = {-16'sd8, 16'sd4, 16'sd3, 16'sd2, 16'sd1, 16'sd0, 16'sd7, 16'sd12, -16'sd3, 16'sd5};
        vecs[0].exp = 8'd2; vecs[0].maxgap = 2'd0;
        vecs[1].s = {10{16'h8000}};
        vecs[1].exp = 8'd0; vecs[1].maxgap = 2'd0;
        vecs[2].s = {16'sd1, 16'sd1, 16'sd1, 16'sd9, 16'sd1, 16'sd1, 16'sd9, 16'sd1, 16'sd1, 16'sd1};
        vecs[2].exp = 8'd3; vecs[2].maxgap = 2'd1;
        vecs[3].s = {-16'sd1, -16'sd2, -16'sd7, -16'sd2, -16'sd300, -16'sd2, -16'sd2, -16'sd32768, -16'sd5, -16'sd2};
        vecs[3].exp = 8'd9; vecs[3].maxgap = 2'd3;
        vecs[4].s = {16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd1, 16'sd32767};
        vecs[4].exp = 8'd0; vecs[4].maxgap = 2'd0;
        vecs[5].s = {16'sd32767, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd1};
        vecs[5].exp = 8'd9; vecs[5].maxgap = 2'd2;

        // Scores before any start are ignored.
        score_valid = 1'b1; score = 16'sd100;
        repeat (3) @(posedge clk);
        #1 score_valid = 1'b0;
        chk("idle_ignore_busy", busy, 0);
        chk("idle_ignore_done", done_cnt, 0);

        // Table vectors.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 10; i++) sc[i] = $signed(vecs[v].s[i]);
            pulse_start();
            run_scores(int'(vecs[v].maxgap), int'(vecs[v].exp));
            after_done(int'(vecs[v].exp));
        end

        // Randomized samples against the reference.
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 10; i++) begin
                if (r % 2 == 0) sc[i] = $signed(16'($urandom));
                else            sc[i] = $signed(16'($urandom_range(0, 6))) - 16'sd3;
            end
            exp = model_argmax();
            pulse_start();
            run_scores(r % 4, exp);
            after_done(exp);
        end

        // Abort: 4 scores, restart with a discarded score, then max at class 1.
        for (int i = 0; i < 10; i++) sc[i] = 16'sd100;
        dc = done_cnt;
        pulse_start();
        feed(4, 0);
        @(posedge clk); #1;
        start = 1'b1; score_valid = 1'b1; score = 16'sd32767;
        @(posedge clk); #1;
        start = 1'b0; score_valid = 1'b0;
        chk("abort_busy", busy, 1);
        for (int i = 0; i < 10; i++) sc[i] = (i == 1) ? 16'sd50 : -16'sd20;
        run_scores(1, 1);
        after_done(1);
        chk("abort_one_done", done_cnt - dc, 1);

        // Reset mid-sample: no done, label cleared, next sample completes.
        for (int i = 0; i < 10; i++) sc[i] = (i == 4) ? 16'sd9 : 16'sd0;
        dc = done_cnt;
        pulse_start();
        feed(6, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_label", label, 0);
        @(posedge clk); #1 rst = 1'b0;
        score_valid = 1'b1; score = 16'sd77;
        repeat (2) @(posedge clk);
        #1 score_valid = 1'b0;
        chk("rst_no_done", done_cnt - dc, 0);
        chk("rst_idle_busy", busy, 0);
        pulse_start();
        run_scores(0, 4);
        after_done(4);

        // Back-to-back samples with start during the DONE cycle.
        dc = done_cnt;
        for (int i = 0; i < 10; i++) sc[i] = (i == 7) ? 16'sd3 : -16'sd3;
        pulse_start();
        run_scores(0, 7);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("chain_busy", busy, 1);
        for (int i = 0; i < 10; i++) sc[i] = (i == 5) ? 16'sd1000 : 16'sd999;
        run_scores(0, 5);
        after_done(5);
        chk("chain_two_done", done_cnt - dc, 2);
        chk("chain_spacing", int'((t_last - t_prev) / 10), 11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
